// File: rtl/instaweb_ingress_arbiter.sv
// Ingress stage of the geodesic router: per-link drop-on-full FIFOs feeding a
// round-robin arbiter and a single valid/ready output register.
module instaweb_ingress_arbiter #(
  parameter  int DATA_WIDTH     = 512,
  parameter  int COORD_WIDTH    = 24,
  parameter  int NEIGHBORS      = 8,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int DROP_CNT_WIDTH = 16,
  localparam int SRC_W          = $clog2(NEIGHBORS)
) (
  input  logic                                clk_synce,
  input  logic                                rst,
  input  logic [NEIGHBORS*DATA_WIDTH-1:0]     link_rx_data,
  input  logic [NEIGHBORS-1:0]                link_rx_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SRC_W-1:0]                    out_src,
  output logic [COORD_WIDTH-1:0]              out_target_coord,
  output logic [NEIGHBORS-1:0]                fifo_full,
  output logic [NEIGHBORS*DROP_CNT_WIDTH-1:0] drop_count,
  input  logic                                drop_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DATA_WIDTH-1:0]     r_mem [NEIGHBORS][FIFO_DEPTH];
  logic [AW-1:0]             r_wptr [NEIGHBORS];
  logic [AW-1:0]             r_rptr [NEIGHBORS];
  logic [CW-1:0]             r_cnt [NEIGHBORS];
  logic [CW-1:0]             w_cnt_nxt [NEIGHBORS];
  logic [NEIGHBORS-1:0]      r_full;
  logic [DROP_CNT_WIDTH-1:0] r_drop [NEIGHBORS];
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [SRC_W-1:0]          r_out_src;
  logic [SRC_W-1:0]          r_rr_ptr;

  logic [NEIGHBORS-1:0]      w_push;
  logic [NEIGHBORS-1:0]      w_drop;
  logic [NEIGHBORS-1:0]      w_pop;
  logic [NEIGHBORS-1:0]      w_nonempty;
  logic                      w_any;
  logic [SRC_W-1:0]          w_grant;
  logic                      w_load_slot;
  logic                      w_load;
  logic [DATA_WIDTH-1:0]     w_head;

  // Full flag is registered, so a push arriving while full is dropped even if
  // the same lane is popped on that edge.
  assign w_push = link_rx_valid & ~r_full;
  assign w_drop = link_rx_valid & r_full;

  always_comb begin
    for (int i = 0; i < NEIGHBORS; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      w_cnt_nxt[i]  = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
    end
  end

  // Round-robin scan starting at r_rr_ptr; lane index wraps in SRC_W bits.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NEIGHBORS; k++) begin
      if (!w_any && w_nonempty[r_rr_ptr + SRC_W'(k)]) begin
        w_any   = 1'b1;
        w_grant = r_rr_ptr + SRC_W'(k);
      end
    end
  end

  assign w_head = r_mem[w_grant][r_rptr[w_grant]];

  always_comb begin
    w_load_slot = (r_state == S_IDLE) || out_ready;
    w_load      = w_load_slot && w_any;
    w_state_nxt = r_state;
    w_pop       = '0;
    if (w_load_slot) begin
      w_state_nxt = w_any ? S_HOLD : S_IDLE;
    end
    if (w_load) begin
      w_pop[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk_synce or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_synce) begin
    for (int i = 0; i < NEIGHBORS; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= link_rx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_synce or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEIGHBORS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_full <= '0;
    end else begin
      for (int i = 0; i < NEIGHBORS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        r_cnt[i]  <= w_cnt_nxt[i];
        r_full[i] <= (w_cnt_nxt[i] == CW'(FIFO_DEPTH));
      end
    end
  end

  always_ff @(posedge clk_synce or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_src  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_load) begin
      r_out_data <= w_head;
      r_out_src  <= w_grant;
      r_rr_ptr   <= w_grant + SRC_W'(1);
    end
  end

  // Clear wins over a same-cycle drop; counters stick at all-ones.
  always_ff @(posedge clk_synce or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEIGHBORS; i++) r_drop[i] <= '0;
    end else begin
      for (int i = 0; i < NEIGHBORS; i++) begin
        if (drop_clear) begin
          r_drop[i] <= '0;
        end else if (w_drop[i] && (r_drop[i] != '1)) begin
          r_drop[i] <= r_drop[i] + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NEIGHBORS; g++) begin : g_drop_out
    assign drop_count[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = r_drop[g];
  end

  assign out_data         = r_out_data;
  assign out_valid        = (r_state == S_HOLD);
  assign out_src          = r_out_src;
  assign out_target_coord = r_out_data[COORD_WIDTH-1:0];
  assign fifo_full        = r_full;

endmodule

// File: tb/tb_instaweb_ingress_arbiter.sv
// Directed bench for instaweb_ingress_arbiter: latency, round-robin order,
// backpressure, overflow, drop-counter saturation/clear and mid-run reset.
module tb_instaweb_ingress_arbiter;

  localparam int DW  = 64;
  localparam int CWD = 24;
  localparam int NB  = 8;
  localparam int DCW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*DW-1:0]  rx_data;
  logic [NB-1:0]     rx_valid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_src;
  logic [CWD-1:0]    out_coord;
  logic [NB-1:0]     fifo_full;
  logic [NB*DCW-1:0] drop_count;
  logic              drop_clear;

  int n_total = 0;
  int n_bad   = 0;

  instaweb_ingress_arbiter #(
    .DATA_WIDTH    (DW),
    .COORD_WIDTH   (CWD),
    .NEIGHBORS     (NB),
    .FIFO_DEPTH    (4),
    .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk_synce       (clk),
    .rst             (rst),
    .link_rx_data    (rx_data),
    .link_rx_valid   (rx_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_src         (out_src),
    .out_target_coord(out_coord),
    .fifo_full       (fifo_full),
    .drop_count      (drop_count),
    .drop_clear      (drop_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] v);
    rx_data[i*DW +: DW] = v;
    rx_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = '0;
    rx_valid   = '0;
    out_ready  = 1'b1;
    drop_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_src",   out_src, 0);
    chk("rst_coord", out_coord, 0);
    chk("rst_full",  fifo_full, 0);
    chk("rst_drop",  drop_count, 0);

    // single flit latency on lane 3
    set_lane(3, 64'hA5A5_0000_0012_3456);
    tick();
    rx_valid = '0;
    chk("lat_t1_valid", out_valid, 0);
    tick();
    chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_src",   out_src, 3);
    chk("lat_t2_coord", out_coord, 24'h123456);
    chk("lat_t2_data",  out_data, 64'hA5A5_0000_0012_3456);
    tick();
    chk("lat_t3_valid", out_valid, 0);

    // all lanes at once: round-robin from lane 0
    do_reset();
    for (int i = 0; i < NB; i++) set_lane(i, 64'h100 + i);
    tick();
    rx_valid = '0;
    tick();
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("rr_valid%0d", k), out_valid, 1);
      chk($sformatf("rr_src%0d", k),   out_src, k);
      chk($sformatf("rr_data%0d", k),  out_data, 64'h100 + k);
      tick();
    end
    chk("rr_drain_valid", out_valid, 0);
    set_lane(7, 64'h77);
    set_lane(0, 64'h70);
    tick();
    rx_valid = '0;
    tick();
    chk("rr_wrap_src0", out_src, 0);
    tick();
    chk("rr_wrap_src7", out_src, 7);
    tick();
    chk("rr_wrap_idle", out_valid, 0);

    // backpressure holds the output register
    out_ready = 1'b0;
    set_lane(1, 64'hBEEF);
    tick();
    rx_valid = '0;
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_src",   out_src, 1);
    chk("bp_data",  out_data, 64'hBEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_hold_src%0d", k),   out_src, 1);
      chk($sformatf("bp_hold_data%0d", k),  out_data, 64'hBEEF);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_consumed", out_valid, 0);

    // overflow on lane 2
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_lane(2, 64'h200 + k);
      tick();
    end
    rx_valid = '0;
    chk("ovf_drop2", drop_count[2*DCW +: DCW], 1);
    chk("ovf_full",  fifo_full, 8'h04);
    chk("ovf_drop_other", drop_count & ~(16'h3 << (2*DCW)), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovf_data%0d", k), out_data, 64'h200 + k);
      chk($sformatf("ovf_src%0d", k),  out_src, 2);
      tick();
      if (k == 0) chk("ovf_full_fall", fifo_full, 0);
    end
    chk("ovf_drained", out_valid, 0);

    // saturation and clear of a 2-bit counter on lane 0
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 64'h300 + k);
      tick();
    end
    chk("sat_three", drop_count[1:0], 3);
    for (int k = 8; k < 10; k++) begin
      set_lane(0, 64'h300 + k);
      tick();
    end
    chk("sat_hold", drop_count[1:0], 3);
    set_lane(0, 64'h3FF);
    drop_clear = 1'b1;
    tick();
    rx_valid   = '0;
    drop_clear = 1'b0;
    chk("sat_clear", drop_count[1:0], 0);

    // asynchronous reset with flits in flight
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_lane(4, 64'h400 + k);
      tick();
    end
    rx_valid = '0;
    chk("mrst_pre_valid", out_valid, 1);
    chk("mrst_pre_src",   out_src, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data",  out_data, 0);
    chk("mrst_src",   out_src, 0);
    chk("mrst_coord", out_coord, 0);
    chk("mrst_full",  fifo_full, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mrst_nostale%0d", k), out_valid, 0);
    end
    set_lane(2, 64'h52);
    set_lane(6, 64'h56);
    tick();
    rx_valid = '0;
    tick();
    chk("mrst_first_src", out_src, 2);
    chk("mrst_first_data", out_data, 64'h52);
    tick();
    chk("mrst_second_src", out_src, 6);
    tick();
    chk("mrst_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instaweb_ingress_arbiter.md
# instaweb_ingress_arbiter

Ingress stage of the ℍ³ geodesic router. It absorbs flits from the `NEIGHBORS` inbound geodesic links into per-link FIFOs and round-robin arbitrates them into a single valid/ready stream. The stream feeds the topology engine's relay input with the flit's source link and extracted target coordinate. Overflow is dropped and counted per link, because inbound links carry no backpressure.

## Interface
- `DATA_WIDTH`, 512: flit width.
- `COORD_WIDTH`, 24: target coordinate header width (r, theta, z; 3 × 8 bit).
- `NEIGHBORS`, 8: number of inbound links; must be a power of 2, ≥ 2.
- `FIFO_DEPTH`, 4: entries per link FIFO; must be a power of 2, ≥ 2.
- `DROP_CNT_WIDTH`, 16: width of each per-link drop counter.
- `SRC_W` (localparam) = `$clog2(NEIGHBORS)`.

Ports:
- `clk_synce`  in  1  single SyncE clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `link_rx_data`  in  `NEIGHBORS*DATA_WIDTH`  flattened; lane i = `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `link_rx_valid`  in  `NEIGHBORS`  per-lane flit strobe; no ready (fire-and-forget).
- `out_data`  out  `DATA_WIDTH`  granted flit.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accept.
- `out_src`  out  `SRC_W`  lane index of `out_data`.
- `out_target_coord`  out  `COORD_WIDTH`  equals `out_data[COORD_WIDTH-1:0]`.
- `fifo_full`  out  `NEIGHBORS`  registered per-lane full flag.
- `drop_count`  out  `NEIGHBORS*DROP_CNT_WIDTH`  saturating per-lane drop counters; lane i = `[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]`.
- `drop_clear`  in  1  synchronous clear of all drop counters.

## Operation

Per-lane FIFO:
- Push when `link_rx_valid[i] && !fifo_full[i]`.
- When `link_rx_valid[i] && fifo_full[i]`, the flit is dropped and `drop_count[i]` increments.
- Full status is the value at the start of the cycle. A push into a full FIFO is dropped even if the same lane is popped that cycle.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits wide.

Output register: a two-state machine.
- IDLE: `out_valid` = 0.
- HOLD: `out_valid` = 1.
- A load slot exists in IDLE, or in HOLD when `out_ready` = 1.
- In a load slot:
  - If any FIFO is non-empty, grant the first non-empty lane scanning `rr_ptr, rr_ptr+1, …` (mod `NEIGHBORS`).
  - Pop that FIFO head into `out_data`, set `out_src` to the granted lane, and go to HOLD.
  - Set `rr_ptr` to (grant + 1) mod `NEIGHBORS`.
  - If no FIFO is non-empty, go to IDLE.
- HOLD with `out_ready` = 0: `out_data`, `out_src` and `out_valid` stay stable; no pop; `rr_ptr` unchanged.

Drop counters:
- Saturate at all-ones.
- `drop_clear` zeroes all counters and takes precedence over a same-cycle drop (result is 0).

Reset values (asynchronous on `rst`): all FIFOs empty, `fifo_full` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `out_target_coord` = 0, `rr_ptr` = 0, all `drop_count` = 0. A reset mid-operation discards all buffered flits and the held output flit.

## Timing
- Flit latency is 2 cycles with an empty path:
  - Flit presented in cycle t is written at edge t.
  - FIFO is non-empty in t+1 and the flit loads at edge t+1.
  - `out_valid` = 1 in cycle t+2.
- Throughput is 1 flit/cycle while `out_ready` is held high and any FIFO is non-empty.
- `fifo_full[i]` rises the cycle after the push that fills the FIFO. It falls the cycle after the first pop.
- `drop_count` updates the cycle after the dropping or clearing edge.
- Effective per-lane buffering under backpressure is `FIFO_DEPTH` plus 1 (the output register).

## Test plan
- Single flit on lane 3 in cycle t, coord field 0x12_34_56, `out_ready` = 1 → cycle t+2: `out_valid` = 1, `out_src` = 3, `out_target_coord` = 0x123456; cycle t+3: `out_valid` = 0.
- All 8 lanes, one flit each in the same cycle, `out_ready` = 1 → `out_src` = 0,1,…,7 on 8 consecutive cycles; next grant starts at lane 0.
- Backpressure: `out_ready` = 0 for 5 cycles while `out_valid` = 1 → `out_data` and `out_src` unchanged; the flit is consumed on the first `out_ready` = 1 edge.
- Overflow: lane 2 receives 6 consecutive flits with `out_ready` = 0 (`FIFO_DEPTH` = 4) → flit 0 in output register, flits 1–4 buffered, flit 5 dropped. Result: `drop_count[2]` = 1, `fifo_full[2]` = 1. Then `out_ready` = 1 → flits 0–4 emerge in order.
- Saturation and clear: force `DROP_CNT_WIDTH` = 2 and drop 5 flits → count holds 3; `drop_clear` asserted in the same cycle as a drop → count = 0.
- Reset mid-operation: assert `rst` with 3 flits buffered and `out_valid` = 1 → all outputs at reset values immediately. After release, no stale flit is emitted and the first grant scans from lane 0.
